// File: rtl/gan_pkg.sv
// gan_pkg: shared constants for the GAN layer scheduler.
//   state_e       scheduler FSM states
//   FANIN/FANOUT  per-layer fan-in / fan-out of the fixed 8-layer topology
//   WBASE/BBASE   per-layer base addresses into weight / bias memories
// Tables are packed with layer 0 in the least-significant element.
package gan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIAS = 2'd1,
    S_MAC  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam int NUM_LAYERS = 8;
  localparam int WB_W       = 6;   // native weight-base width (54 entries)
  localparam int BB_W       = 5;   // native bias-base width (19 entries)

  //                                      L7     L6     L5     L4     L3     L2     L1     L0
  localparam logic [7:0][2:0]      FANIN  = {3'd4,  3'd2,  3'd1,  3'd1,  3'd1,  3'd2,  3'd4,  3'd4};
  localparam logic [7:0][2:0]      FANOUT = {3'd4,  3'd4,  3'd2,  3'd1,  3'd1,  3'd1,  3'd2,  3'd4};
  localparam logic [7:0][WB_W-1:0] WBASE  = {6'd38, 6'd30, 6'd28, 6'd27, 6'd26, 6'd24, 6'd16, 6'd0};
  localparam logic [7:0][BB_W-1:0] BBASE  = {5'd15, 5'd11, 5'd9,  5'd8,  5'd7,  5'd6,  5'd4,  5'd0};

endpackage

// File: rtl/gan_layer_rom.sv
// gan_layer_rom: combinational layer-index lookup.
//   layer_i    in   current layer 0..7
//   fan_in_o   out  inputs per neuron in this layer (1..4)
//   fan_out_o  out  neurons in this layer (1..4)
//   wbase_o    out  first weight address of this layer
//   bbase_o    out  first bias address of this layer
module gan_layer_rom
  import gan_pkg::*;
(
  input  logic [2:0]      layer_i,
  output logic [2:0]      fan_in_o,
  output logic [2:0]      fan_out_o,
  output logic [WB_W-1:0] wbase_o,
  output logic [BB_W-1:0] bbase_o
);

  assign fan_in_o  = FANIN[layer_i];
  assign fan_out_o = FANOUT[layer_i];
  assign wbase_o   = WBASE[layer_i];
  assign bbase_o   = BBASE[layer_i];

endmodule

// File: rtl/gan_layer_sched.sv
// gan_layer_sched: sequences one 8-layer inference pass of a tiny GAN MLP.
// Each neuron costs BIAS (load bias), fan_in x MAC, then WB (write result).
//   clk, rst_n             clock, async active-low reset
//   start                  request a pass (ignored while busy)
//   stall                  optional freeze input, present only when
//                          GAN_SCHED_STALL_EN is defined
//   busy / done            pass in progress / one-cycle completion pulse
//   layer                  current layer 0..7
//   w_addr / b_addr        weight / bias memory addresses
//   act_rd_idx/act_wr_idx  source input i / destination neuron n
//   act_bank               source activation bank (layer[0])
//   acc_ld/mac_en/act_we   BIAS / MAC / WB strobes
module gan_layer_sched
  import gan_pkg::*;
#(
  parameter int W_AW = 6,
  parameter int B_AW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef GAN_SCHED_STALL_EN
  input  logic            stall,
`endif
  output logic            busy,
  output logic            done,
  output logic [2:0]      layer,
  output logic [W_AW-1:0] w_addr,
  output logic [B_AW-1:0] b_addr,
  output logic [1:0]      act_rd_idx,
  output logic [1:0]      act_wr_idx,
  output logic            act_bank,
  output logic            acc_ld,
  output logic            mac_en,
  output logic            act_we
);

  logic stall_w;
`ifdef GAN_SCHED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  state_e     state_q;
  logic [2:0] layer_q;
  logic [1:0] n_q;      // neuron within layer
  logic [1:0] i_q;      // input within neuron
  logic       done_q;   // pending done; held across stall cycles

  logic [2:0]      fan_in, fan_out;
  logic [WB_W-1:0] wbase, w_off, wsum;
  logic [BB_W-1:0] bbase, bsum;

  gan_layer_rom u_rom (
    .layer_i   (layer_q),
    .fan_in_o  (fan_in),
    .fan_out_o (fan_out),
    .wbase_o   (wbase),
    .bbase_o   (bbase)
  );

  logic last_i, last_n, last_l;
  assign last_i = ({1'b0, i_q} == fan_in  - 3'd1);
  assign last_n = ({1'b0, n_q} == fan_out - 3'd1);
  assign last_l = (layer_q == 3'(NUM_LAYERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      n_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
    end else if (!stall_w) begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) state_q <= S_BIAS;
        S_BIAS: begin
          i_q     <= '0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          if (last_i) state_q <= S_WB;
          else        i_q     <= i_q + 2'd1;
        end
        S_WB: begin
          i_q <= '0;
          if (!last_n) begin
            n_q     <= n_q + 2'd1;
            state_q <= S_BIAS;
          end else begin
            n_q <= '0;
            if (last_l) begin
              // Counters return to 0 so IDLE shows reset-value addresses.
              layer_q <= '0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              layer_q <= layer_q + 3'd1;
              state_q <= S_BIAS;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Addresses are pure functions of the counters, so they hold during stall.
  assign w_off = WB_W'(n_q) * WB_W'(fan_in) + WB_W'(i_q);
  assign wsum  = wbase + w_off;
  assign bsum  = bbase + BB_W'(n_q);

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q & ~stall_w;
  assign layer      = layer_q;
  assign w_addr     = W_AW'(wsum);
  assign b_addr     = B_AW'(bsum);
  assign act_rd_idx = i_q;
  assign act_wr_idx = n_q;
  assign act_bank   = layer_q[0];
  assign acc_ld     = (state_q == S_BIAS) & ~stall_w;
  assign mac_en     = (state_q == S_MAC)  & ~stall_w;
  assign act_we     = (state_q == S_WB)   & ~stall_w;

endmodule

// File: tb/tb_gan_layer_sched.sv
// tb_gan_layer_sched: self-checking bench for gan_layer_sched.
// The reference model expands a whole pass into a queue of expected per-cycle
// observations from the topology tables (bases derived as prefix sums), and
// pops one entry per non-stalled clock.
`timescale 1ns/1ps
module tb_gan_layer_sched;

`ifdef GAN_SCHED_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, stall_s = 1'b0;
  logic busy, done, act_bank, acc_ld, mac_en, act_we;
  logic [2:0] layer;
  logic [5:0] w_addr;
  logic [4:0] b_addr;
  logic [1:0] act_rd_idx, act_wr_idx;

  always #5 clk = ~clk;

  gan_layer_sched #(.W_AW(6), .B_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef GAN_SCHED_STALL_EN
    .stall(stall_s),
`endif
    .busy(busy), .done(done), .layer(layer), .w_addr(w_addr), .b_addr(b_addr),
    .act_rd_idx(act_rd_idx), .act_wr_idx(act_wr_idx), .act_bank(act_bank),
    .acc_ld(acc_ld), .mac_en(mac_en), .act_we(act_we)
  );

  typedef struct packed {
    logic       busy, done;
    logic [2:0] layer;
    logic [5:0] wa;
    logic [4:0] ba;
    logic [1:0] rd, wr;
    logic       bank, ld, mac, we;
  } obs_t;

  typedef struct { obs_t e; obs_t m; } rec_t;

  int FI[8] = '{4, 4, 2, 1, 1, 1, 2, 4};
  int FO[8] = '{4, 2, 1, 1, 1, 2, 4, 4};

  rec_t q[$];
  int nvec = 0, nerr = 0, cyc = 0;
  int ndone = 0, last_done = 0, nmac = 0, nld = 0, nwe = 0;
  int dq[$];
  logic [8:0] mtr[$];   // {layer, w_addr} on mac_en cycles
  logic [4:0] btr[$];   // b_addr on acc_ld cycles

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_pass();
    rec_t r, x;
    int wb = 0, bb = 0;
    for (int l = 0; l < 8; l++) begin
      for (int n = 0; n < FO[l]; n++) begin
        r.e = '0; r.m = '1;
        r.e.busy = 1'b1; r.e.layer = 3'(l); r.e.bank = l[0];
        r.e.ba = 5'(bb + n); r.e.wr = 2'(n);
        x = r; x.e.ld = 1'b1; x.m.wa = '0; x.m.rd = '0; q.push_back(x);
        for (int i = 0; i < FI[l]; i++) begin
          x = r; x.e.mac = 1'b1; x.e.wa = 6'(wb + n * FI[l] + i); x.e.rd = 2'(i);
          q.push_back(x);
        end
        x = r; x.e.we = 1'b1; x.m.wa = '0; x.m.rd = '0; q.push_back(x);
      end
      wb += FI[l] * FO[l];
      bb += FO[l];
    end
    r.e = '0; r.m = '1; r.e.done = 1'b1; q.push_back(r);
  endtask

  task automatic compare();
    rec_t h;
    obs_t o;
    h.e = '0; h.m = '1;
    if (q.size() != 0) h = q[0];
    if (stall_s) begin
      h.e.ld = 1'b0; h.e.mac = 1'b0; h.e.we = 1'b0; h.e.done = 1'b0;
    end
    o = {busy, done, layer, w_addr, b_addr, act_rd_idx, act_wr_idx,
         act_bank, acc_ld, mac_en, act_we};
    chk("outputs", 32'(o & h.m), 32'(h.e & h.m));
    if (h.e.busy)
      chk("idx_range", {30'd0, 32'(act_rd_idx) < FI[h.e.layer], 32'(act_wr_idx) < FO[h.e.layer]}, 32'd3);
    if (done)   begin ndone++; last_done = cyc; dq.push_back(cyc); end
    if (mac_en) begin nmac++; mtr.push_back({layer, w_addr}); end
    if (acc_ld) begin nld++;  btr.push_back(b_addr); end
    if (act_we) nwe++;
  endtask

  task automatic model_edge();
    if (!rst_n || stall_s) return;
    if (q.size() == 0 || !q[0].e.busy) begin
      if (q.size() != 0) void'(q.pop_front());
      if (start) push_pass();
    end else begin
      void'(q.pop_front());
    end
  endtask

  task automatic step(input logic st, input logic sl, input logic rn);
    @(negedge clk);
    start = st; stall_s = sl; rst_n = rn;
    if (!rn) q.delete();
    #1 compare();
    @(posedge clk);
    cyc++;
    model_edge();
  endtask

  task automatic run_to_done(input int maxc, input string tag);
    int d0 = ndone;
    for (int k = 0; k < maxc && ndone == d0; k++) step(1'b0, 1'b0, 1'b1);
    chk(tag, ndone - d0, 1);
  endtask

  task automatic clr_tally();
    nmac = 0; nld = 0; nwe = 0;
    mtr.delete(); btr.delete(); dq.delete();
  endtask

  initial begin
    int acc, d0, k2;
    logic [5:0] wsave;
    logic [4:0] bsave;

    // reset state
    #1 compare();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // single clean pass: latency, strobe counts, address trace
    clr_tally();
    step(1'b1, 1'b0, 1'b1);
    acc = cyc;
    #1 chk("busy_after_start", 32'(busy), 32'd1);
    run_to_done(200, "pass1_done");
    chk("latency", last_done - acc, 92);
    chk("mac_cnt", nmac, 54);
    chk("ld_cnt", nld, 19);
    chk("we_cnt", nwe, 19);
    chk("first_bias_baddr", 32'(btr[0]), 0);
    chk("last_bias_baddr", 32'(btr[btr.size()-1]), 18);
    for (int i = 0; i < 4; i++) chk("first_mac_waddr", 32'(mtr[i][5:0]), i);
    chk("last_mac_waddr", 32'(mtr[mtr.size()-1][5:0]), 53);
    k2 = 0;
    foreach (mtr[j]) if (mtr[j][8:6] == 3'd2) begin
      chk("layer3_mac_waddr", 32'(mtr[j][5:0]), 24 + k2);
      k2++;
    end
    chk("layer3_mac_cnt", k2, 2);

    // start held 200 cycles: restart accepted in the done cycle
    step(1'b0, 1'b0, 1'b1);
    clr_tally();
    step(1'b1, 1'b0, 1'b1);
    acc = cyc;
    for (int k = 1; k < 200; k++) step(1'b1, 1'b0, 1'b1);
    chk("held_two_passes", dq.size(), 2);
    chk("held_first_done", dq[0] - acc, 92);
    chk("held_done_gap", dq[1] - dq[0], 93);
    run_to_done(200, "held_drain");

    // reset at cycle 40 of a pass
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    acc = cyc;
    for (int k = 1; k < 40; k++) step(1'b0, 1'b0, 1'b1);
    d0 = ndone;
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1 chk("async_rst_outs", {28'd0, busy, acc_ld, mac_en, act_we}, 32'd0);
    compare();
    @(posedge clk); cyc++; model_edge();
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 1'b1);
    chk("no_done_after_rst", ndone - d0, 0);
    step(1'b1, 1'b0, 1'b1);
    acc = cyc;
    run_to_done(200, "post_rst_done");
    chk("post_rst_latency", last_done - acc, 92);

    // 10 stall cycles mid-layer-2
    if (HAS_STALL) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      acc = cyc;
      for (int k = 1; k < 28; k++) step(1'b0, 1'b0, 1'b1);
      wsave = w_addr; bsave = b_addr;
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 1'b1, 1'b1);
        #1;
        chk("stall_strobes", {29'd0, acc_ld, mac_en, act_we}, 32'd0);
        chk("stall_addr", {21'd0, w_addr, b_addr}, {21'd0, wsave, bsave});
      end
      run_to_done(300, "stall_done");
      chk("stall_latency", last_done - acc, 102);
    end

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic st, sl, rn;
      st = ($urandom_range(0, 7) == 0);
      sl = HAS_STALL && ($urandom_range(0, 5) == 0);
      rn = ($urandom_range(0, 399) != 0);
      step(st, sl, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gan_layer_sched.md
GAN_LAYER_SCHED -- requirements
Module: gan_layer_sched

Interface
REQ-001 SHALL have parameter W_AW, default 6: weight-address width, holding 54 weight entries.
REQ-002 SHALL have parameter B_AW, default 5: bias-address width, holding 19 bias entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request one full 8-layer inference pass.
REQ-006 SHALL have port busy  output  1  high from start acceptance until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the pass completes.
REQ-008 SHALL have port layer  output  3  current layer index 0..7 (layer 1..8).
REQ-009 SHALL have port w_addr  output  W_AW  weight-memory address, combinational from state.
REQ-010 SHALL have port b_addr  output  B_AW  bias-memory address, combinational from state.
REQ-011 SHALL have port act_rd_idx  output  2  source-activation index (input i).
REQ-012 SHALL have port act_wr_idx  output  2  destination-activation index (neuron n).
REQ-013 SHALL have port act_bank  output  1  source bank; bank = layer[0]; destination = ~layer[0].
REQ-014 SHALL have port acc_ld  output  1  load bias into MAC accumulator.
REQ-015 SHALL have port mac_en  output  1  accumulate weight*activation.
REQ-016 SHALL have port act_we  output  1  write accumulator result to destination bank.

Function
REQ-017 SHALL use fixed topology, fan-in/fan-out per layer: 4/4, 4/2, 2/1, 1/1, 1/1, 1/2, 2/4, 4/4.
REQ-018 SHALL use FSM states IDLE, BIAS, MAC, WB; transitions are IDLE->BIAS on start, BIAS->MAC, MAC->MAC while i<fan_in-1, MAC->WB, WB->BIAS next neuron or next layer, and WB->IDLE after layer 8 neuron 3.
REQ-019 SHALL assert acc_ld only in BIAS, mac_en only in MAC, and act_we only in WB, with at most one strobe high per cycle.
REQ-020 SHALL drive b_addr = BBASE[layer]+n, with BBASE = 0,4,6,7,8,9,11,15.
REQ-021 SHALL drive w_addr = WBASE[layer]+n*fan_in+i, with WBASE = 0,16,24,26,27,28,30,38.
REQ-022 SHALL use a per-neuron cost of 1 BIAS + fan_in MAC + 1 WB cycles; a pass is 92 cycles, start-accept edge to done.
REQ-023 SHALL pulse done for one cycle in the cycle after the final WB, with busy low in that same cycle.
REQ-024 SHALL ignore start while busy, and SHALL accept start in the done cycle as a new pass.
REQ-025 SHALL hold outputs at reset values in IDLE, with addresses at 0.
REQ-026 SHALL wrap neuron and input counters to 0 on each layer advance; the layer counter SHALL never exceed 7.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, all counters 0, and busy, done, acc_ld, mac_en and act_we 0.
REQ-028 SHALL, on rst_n asserted mid-pass, abandon the pass with no done pulse; the next start SHALL restart at layer 1 neuron 0.

Configuration
REQ-029 SHALL, with GAN_SCHED_STALL_EN defined, add input stall (1 bit).
REQ-030 SHALL, while stall is high, freeze state and counters and force all strobes low; addresses SHALL hold.
REQ-031 SHALL, while stall is high in the done cycle, delay the done pulse until the first non-stall cycle.
REQ-032 SHALL, without GAN_SCHED_STALL_EN defined, omit the stall port and behave as if stall = 0.

Structure
REQ-033 SHALL place the FANIN, FANOUT, WBASE and BBASE constant tables and the state enum in shared package gan_pkg.
REQ-034 SHALL use one sub-module, gan_layer_rom, for combinational layer-index-to-{fan_in, fan_out, wbase, bbase} lookup; the rest is flat.

Verification
REQ-035 SHALL verify: start pulse in IDLE -> busy next cycle; done exactly 92 cycles after acceptance; exactly 54 mac_en, 19 acc_ld and 19 act_we cycles.
REQ-036 SHALL verify: address trace -> first BIAS b_addr=0; first MAC w_addr 0..3; layer 3 MAC w_addr 24,25; last MAC w_addr=53; last BIAS b_addr=18.
REQ-037 SHALL verify: start held high for 200 cycles -> two passes; second done 93 cycles after the first, with the restart accepted in the done cycle.
REQ-038 SHALL verify: rst_n low at cycle 40 -> all strobes 0 asynchronously; no done pulse; the next pass completes in 92 cycles.
REQ-039 SHALL verify, with GAN_SCHED_STALL_EN defined: 10 stall cycles inserted mid-layer-2 -> done at cycle 102; strobes low and addresses frozen during stall.
REQ-040 SHALL verify: act_bank toggles at each layer advance (0,1,0,...); act_wr_idx stays <fan_out and act_rd_idx <fan_in throughout.
